instr_dispatcher: RTL



---
 rtl/tpu_package.sv | 35 +++
 rtl/instr_decoder.sv | 37 +++
 rtl/instr_dispatcher.sv | 110 +++++++++++
 3 files changed

// File: rtl/tpu_package.sv
// Shared types and constants for the TPU front end: instruction layout,
// opcodes and the dispatcher FSM states.
package tpu_package;

    localparam int INSTR_SIZE = 32;
    localparam int OPC_W      = 4;
    localparam int ADDR_W     = 12;
    localparam int LEN_W      = 16;
    localparam int CNT_W      = 16;

    typedef enum logic [OPC_W-1:0] {
        OPC_NOP    = 4'd0,
        OPC_LOAD_W = 4'd1,
        OPC_MATMUL = 4'd2,
        OPC_STORE  = 4'd3,
        OPC_SYNC   = 4'd4,
        OPC_HALT   = 4'd5
    } opcode_t;

    typedef struct packed {
        opcode_t             opcode;
        logic [ADDR_W-1:0]   addr;
        logic [LEN_W-1:0]    len;
    } instr_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_SYNC    = 3'd4,
        ST_HALTED  = 3'd5
    } dispatch_state_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode: one-hot execution-unit select plus the
// control-instruction flags, and the raw address/length fields.
module instr_decoder
    import tpu_package::*;
(
    input  instr_t              instr,
    output logic [2:0]          unit_sel,
    output logic                is_sync,
    output logic                is_halt,
    output logic                is_nop,
    output logic                is_illegal,
    output logic [ADDR_W-1:0]   addr,
    output logic [LEN_W-1:0]    len
);

    // unit_sel bit0 = weight loader, bit1 = matmul, bit2 = store
    always_comb begin
        unit_sel   = 3'b000;
        is_sync    = 1'b0;
        is_halt    = 1'b0;
        is_nop     = 1'b0;
        is_illegal = 1'b0;
        case (instr.opcode)
            OPC_NOP:    is_nop      = 1'b1;
            OPC_LOAD_W: unit_sel    = 3'b001;
            OPC_MATMUL: unit_sel    = 3'b010;
            OPC_STORE:  unit_sel    = 3'b100;
            OPC_SYNC:   is_sync     = 1'b1;
            OPC_HALT:   is_halt     = 1'b1;
            default:    is_illegal  = 1'b1;
        endcase
    end

    assign addr = instr.addr;
    assign len  = instr.len;

endmodule

// File: rtl/instr_dispatcher.sv
// In-order instruction dispatcher: pops the instruction queue one entry at a
// time and hands each command to its execution unit over valid/ready.
module instr_dispatcher #(
    parameter int INSTR_SIZE = 32,
    parameter int ADDR_W     = 12,
    parameter int LEN_W      = 16,
    parameter int CNT_W      = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   iq_empty_i,
    input  logic [INSTR_SIZE-1:0]  instruction_i,
    output logic                   iq_read_o,
    output logic                   wl_valid_o,
    input  logic                   wl_ready_i,
    output logic                   mm_valid_o,
    input  logic                   mm_ready_i,
    output logic                   st_valid_o,
    input  logic                   st_ready_i,
    output logic [ADDR_W-1:0]      cmd_addr_o,
    output logic [LEN_W-1:0]       cmd_len_o,
    input  logic [2:0]             units_busy_i,
    input  logic                   resume_i,
    output logic                   halted_o,
    output logic                   illegal_o,
    output logic [CNT_W-1:0]       instr_count_o
);
    import tpu_package::*;

    dispatch_state_t    state;
    dispatch_state_t    next_state;
    instr_t             instr_q;
    instr_t             dec_in;
    logic [2:0]         unit_sel;
    logic               is_sync;
    logic               is_halt;
    logic               is_nop;
    logic               is_illegal;
    logic [ADDR_W-1:0]  dec_addr;
    logic [LEN_W-1:0]   dec_len;
    logic               issuing;
    logic               handshake;
    logic               retire;

    // Decode the live queue data while capturing, the held instruction otherwise
    assign dec_in = (state == ST_CAPTURE) ? instr_t'(instruction_i) : instr_q;

    instr_decoder decoder (
        .instr      (dec_in),
        .unit_sel   (unit_sel),
        .is_sync    (is_sync),
        .is_halt    (is_halt),
        .is_nop     (is_nop),
        .is_illegal (is_illegal),
        .addr       (dec_addr),
        .len        (dec_len)
    );

    assign issuing    = (state == ST_ISSUE);
    assign wl_valid_o = issuing & unit_sel[0];
    assign mm_valid_o = issuing & unit_sel[1];
    assign st_valid_o = issuing & unit_sel[2];
    assign handshake  = issuing & (|(unit_sel & {st_ready_i, mm_ready_i, wl_ready_i}));
    assign iq_read_o  = (state == ST_FETCH);
    assign halted_o   = (state == ST_HALTED);

    assign retire = ((state == ST_CAPTURE) & (is_nop | is_halt | is_illegal))
                  | handshake
                  | ((state == ST_SYNC) & (units_busy_i == 3'b000));

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (!iq_empty_i) next_state = ST_FETCH;
            ST_FETCH:   next_state = ST_CAPTURE;
            ST_CAPTURE: begin
                if (|unit_sel)    next_state = ST_ISSUE;
                else if (is_sync) next_state = ST_SYNC;
                else if (is_halt) next_state = ST_HALTED;
                else              next_state = ST_IDLE;
            end
            ST_ISSUE:   if (handshake) next_state = ST_IDLE;
            ST_SYNC:    if (units_busy_i == 3'b000) next_state = ST_IDLE;
            ST_HALTED:  if (resume_i) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Command fields only load on capture so they stay stable through backpressure
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= ST_IDLE;
            instr_q       <= '0;
            cmd_addr_o    <= '0;
            cmd_len_o     <= '0;
            illegal_o     <= 1'b0;
            instr_count_o <= '0;
        end else begin
            state <= next_state;
            if (state == ST_CAPTURE) begin
                instr_q    <= instr_t'(instruction_i);
                cmd_addr_o <= dec_addr;
                cmd_len_o  <= dec_len;
                if (is_illegal) illegal_o <= 1'b1;
            end
            if (retire) instr_count_o <= instr_count_o + CNT_W'(1);
        end
    end

endmodule
